// File: rtl/hist_pkg.sv
// hist_pkg: shared frame constants, command fields and state encoding for the histogram readout
package hist_pkg;
    localparam logic [7:0] FRAME_HDR = 8'hA5;
    localparam int SEL_LSB = 0;
    localparam int SEL_W   = 2;
    localparam int CLR_BIT = 7;
    localparam int HWORD   = 32;

    typedef enum logic [1:0] {
        SEL_NONE  = 2'b00,
        SEL_HISTO = 2'b01,
        SEL_IPI   = 2'b10,
        SEL_BOTH  = 2'b11
    } sel_e;

    typedef enum logic [2:0] {IDLE, SNAP, HDR, DATA, TRL, CLR} state_e;

    function automatic sel_e cmd_sel(input logic [7:0] cmd);
        return sel_e'(cmd[SEL_LSB +: SEL_W]);
    endfunction
endpackage

// File: rtl/hist_byte_mux.sv
// hist_byte_mux: picks byte lane i_lane of shadow word i_word from the flattened snapshot
module hist_byte_mux
    import hist_pkg::*;
#(
    parameter int NWORDS = 72,
    parameter int KW     = $clog2(NWORDS)
) (
    input  logic [NWORDS*HWORD-1:0] i_shadow,
    input  logic [KW-1:0]           i_word,
    input  logic [1:0]              i_lane,
    output logic [7:0]              o_byte
);
    logic [HWORD-1:0] w_word;

    assign w_word = i_shadow[i_word*HWORD +: HWORD];
    assign o_byte = w_word[i_lane*8 +: 8];
endmodule

// File: rtl/hist_readout.sv
// hist_readout: snapshots the photon/interval histograms on command and streams them as a checksummed byte frame
module hist_readout
    import hist_pkg::*;
#(
    parameter int NBINS      = 8,
    parameter int NIPI       = 64,
    parameter int RST_CYCLES = 4
) (
    input  logic                    clkin,
    input  logic                    nrst,
    input  logic [NBINS*HWORD-1:0]  histo_flat,
    input  logic [NIPI*HWORD-1:0]   ipi_flat,
    input  logic [7:0]              cmd_data,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    resethist,
    output logic                    busy
);
    localparam int NW = NBINS + NIPI;
    localparam int IW = $clog2(4*NW);
    localparam int RW = $clog2(RST_CYCLES + 1);

    state_e               r_state;
    logic [NW*HWORD-1:0]  r_shadow;
    logic [7:0]           r_cmd;
    logic [7:0]           r_csum;
    logic [7:0]           r_tx_data;
    logic                 r_tx_valid;
    logic                 r_resethist;
    logic [IW-1:0]        r_idx;
    logic [RW-1:0]        r_rst_cnt;

    sel_e                 w_sel;
    logic [IW-1:0]        w_start;
    logic [IW-1:0]        w_last;
    logic [IW-1:0]        w_mux_idx;
    logic [7:0]           w_byte;

    assign w_sel     = cmd_sel(r_cmd);
    assign w_start   = (w_sel == SEL_IPI) ? IW'(4*NBINS) : '0;
    assign w_last    = (w_sel == SEL_HISTO) ? IW'(4*NBINS-1) : IW'(4*NW-1);
    // Look one byte ahead so the next byte is registered on the transferring edge.
    assign w_mux_idx = (r_state == DATA) ? r_idx + 1'b1 : w_start;

    hist_byte_mux #(.NWORDS(NW), .KW(IW-2)) u_mux (
        .i_shadow (r_shadow),
        .i_word   (w_mux_idx[IW-1:2]),
        .i_lane   (w_mux_idx[1:0]),
        .o_byte   (w_byte)
    );

    always_ff @(posedge clkin or negedge nrst) begin
        if (!nrst) begin
            r_state     <= IDLE;
            r_shadow    <= '0;
            r_cmd       <= '0;
            r_csum      <= '0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_resethist <= 1'b0;
            r_idx       <= '0;
            r_rst_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: if (cmd_valid) begin
                    r_cmd <= cmd_data;
                    if (cmd_data[CLR_BIT] || cmd_sel(cmd_data) != SEL_NONE) r_state <= SNAP;
                end
                SNAP: begin
                    r_shadow <= {ipi_flat, histo_flat};
                    r_csum   <= '0;
                    r_idx    <= '0;
                    if (w_sel != SEL_NONE) begin
                        r_state    <= HDR;
                        r_tx_data  <= FRAME_HDR;
                        r_tx_valid <= 1'b1;
                    end else begin
                        r_state     <= CLR;
                        r_resethist <= 1'b1;
                        r_rst_cnt   <= '0;
                    end
                end
                // r_idx[0] marks that the command echo is on the bus.
                HDR: if (tx_ready) begin
                    if (!r_idx[0]) begin
                        r_tx_data <= r_cmd;
                        r_idx     <= IW'(1);
                    end else begin
                        r_state   <= DATA;
                        r_idx     <= w_start;
                        r_tx_data <= w_byte;
                    end
                end
                DATA: if (tx_ready) begin
                    r_csum <= r_csum ^ r_tx_data;
                    if (r_idx == w_last) begin
                        r_state   <= TRL;
                        r_tx_data <= r_csum ^ r_tx_data;
                    end else begin
                        r_idx     <= r_idx + 1'b1;
                        r_tx_data <= w_byte;
                    end
                end
                TRL: if (tx_ready) begin
                    r_tx_valid <= 1'b0;
                    if (r_cmd[CLR_BIT]) begin
                        r_state     <= CLR;
                        r_resethist <= 1'b1;
                        r_rst_cnt   <= '0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                CLR: begin
                    r_rst_cnt <= r_rst_cnt + 1'b1;
                    if (r_rst_cnt == RW'(RST_CYCLES-1)) begin
                        r_resethist <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign resethist = r_resethist;
endmodule

// File: tb/tb_hist_readout.sv
// tb_hist_readout: scoreboard bench; stimulus pushes expected frames, a negedge monitor pops and compares
module tb_hist_readout;
    localparam int NBINS = 8;
    localparam int NIPI  = 64;

    logic                 clkin = 1'b0;
    logic                 nrst;
    logic [NBINS*32-1:0]  histo_flat;
    logic [NIPI*32-1:0]   ipi_flat;
    logic [7:0]           cmd_data;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 resethist;
    logic                 busy;

    logic [31:0] h [NBINS];
    logic [31:0] p [NIPI];
    logic [7:0]  exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          nbytes = 0;
    logic        held_v = 1'b0;
    logic [7:0]  held_d = '0;
    bit          tog = 1'b0;

    always #5 clkin = ~clkin;

    always_comb begin
        histo_flat = '0;
        ipi_flat   = '0;
        for (int i = 0; i < NBINS; i++) histo_flat[32*i +: 32] = h[i];
        for (int k = 0; k < NIPI; k++) ipi_flat[32*k +: 32] = p[k];
    end

    hist_readout #(.NBINS(NBINS), .NIPI(NIPI), .RST_CYCLES(4)) dut (
        .clkin      (clkin),
        .nrst       (nrst),
        .histo_flat (histo_flat),
        .ipi_flat   (ipi_flat),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .resethist  (resethist),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] c);
        logic [7:0] cs;
        logic [7:0] b;
        cs = '0;
        if (c[1:0] == 2'b00) return;
        exp_q.push_back(8'hA5);
        exp_q.push_back(c);
        if (c[0]) for (int w = 0; w < NBINS; w++) for (int j = 0; j < 4; j++) begin
            b = h[w][8*j +: 8];
            cs ^= b;
            exp_q.push_back(b);
        end
        if (c[1]) for (int w = 0; w < NIPI; w++) for (int j = 0; j < 4; j++) begin
            b = p[w][8*j +: 8];
            cs ^= b;
            exp_q.push_back(b);
        end
        exp_q.push_back(cs);
    endtask

    task automatic send_cmd(input logic [7:0] c, output int stalls);
        @(posedge clkin); #1;
        cmd_data  = c;
        cmd_valid = 1'b1;
        stalls    = 0;
        @(negedge clkin);
        while (!cmd_ready && stalls <= 5000) begin
            stalls++;
            @(negedge clkin);
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept_timeout: got cmd_ready=0 expected 1");
        end
        @(posedge clkin); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        @(negedge clkin);
        while (busy && cyc <= 5000) begin
            cyc++;
            @(negedge clkin);
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=1 expected 0");
        end
    endtask

    // tx_ready changes just after each rising edge so the monitor sees it settled
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clkin); #1;
            tx_ready = tog ? ~tx_ready : 1'b1;
        end
    end

    always @(negedge clkin) begin
        if (!nrst) begin
            held_v = 1'b0;
        end else begin
            if (held_v && tx_valid) chk("stall_hold", {24'h0, tx_data}, {24'h0, held_d});
            if (tx_valid && tx_ready) begin
                nbytes++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_byte: got %0h expected no byte", tx_data);
                end else begin
                    chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
                end
            end
            held_v = tx_valid && !tx_ready;
            held_d = tx_data;
        end
    end

    initial begin
        int cyc, st, n0, n;
        nrst      = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        for (int i = 0; i < NBINS; i++) h[i] = 32'h1122_3300 + i;
        for (int k = 0; k < NIPI; k++) p[k] = k;
        repeat (3) @(negedge clkin);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_resethist", resethist, 0);
        chk("rst_busy", busy, 0);
        @(posedge clkin); #1;
        nrst = 1'b1;

        // histo-only frame, ready held high
        n0 = nbytes;
        push_frame(8'h01);
        send_cmd(8'h01, st);
        wait_idle(cyc);
        chk("h_busy_cycles", cyc, 36);
        chk("h_frame_len", nbytes - n0, 35);
        chk("h_queue_empty", exp_q.size(), 0);

        // both histograms, ready toggling, live data changed right after the snapshot
        tog = 1'b1;
        n0 = nbytes;
        push_frame(8'h03);
        send_cmd(8'h03, st);
        @(posedge clkin); #1;
        for (int i = 0; i < NBINS; i++) h[i] = 32'hDEAD_0000 + i;
        h[3] = 32'hFFFF_FFFF;
        p[5] = 32'h8000_0001;
        wait_idle(cyc);
        tog = 1'b0;
        chk("b_frame_len", nbytes - n0, 291);
        chk("b_queue_empty", exp_q.size(), 0);

        // ipi frame then clear pulse
        n0 = nbytes;
        push_frame(8'h82);
        send_cmd(8'h82, st);
        n = 0;
        @(negedge clkin);
        while (!resethist && n < 2000) begin
            n++;
            @(negedge clkin);
        end
        chk("i_frame_len", nbytes - n0, 259);
        n = 0;
        while (resethist && n < 20) begin
            n++;
            @(negedge clkin);
        end
        chk("i_clr_cycles", n, 4);
        chk("i_ready_after", cmd_ready, 1);
        chk("i_queue_empty", exp_q.size(), 0);

        // clear only: pulse starts the cycle after SNAP, no bytes
        n0 = nbytes;
        send_cmd(8'h80, st);
        @(negedge clkin);
        chk("c_snap_no_pulse", resethist, 0);
        @(negedge clkin);
        n = 0;
        while (resethist && n < 20) begin
            n++;
            @(negedge clkin);
        end
        chk("c_clr_cycles", n, 4);
        chk("c_ready_after", cmd_ready, 1);
        chk("c_no_bytes", nbytes - n0, 0);

        // no-op command
        send_cmd(8'h00, st);
        @(negedge clkin);
        chk("n_ready", cmd_ready, 1);
        chk("n_busy", busy, 0);
        chk("n_no_bytes", nbytes - n0, 0);

        // second command while busy waits for the first frame to finish
        n0 = nbytes;
        push_frame(8'h01);
        send_cmd(8'h01, st);
        chk("q_ready_busy", cmd_ready, 0);
        push_frame(8'h02);
        send_cmd(8'h02, st);
        chk("q_stall_cycles", st, 35);
        wait_idle(cyc);
        chk("q_frame_len", nbytes - n0, 35 + 259);
        chk("q_queue_empty", exp_q.size(), 0);

        // reset mid-frame
        n0 = nbytes;
        push_frame(8'h83);
        send_cmd(8'h83, st);
        n = 0;
        while (nbytes - n0 < 100 && n < 2000) begin
            @(posedge clkin); #2;
            n++;
        end
        chk("r_reached_byte100", nbytes - n0, 100);
        nrst = 1'b0;
        #1;
        chk("r_tx_valid", tx_valid, 0);
        chk("r_resethist", resethist, 0);
        chk("r_busy", busy, 0);
        chk("r_cmd_ready", cmd_ready, 1);
        chk("r_tx_data", tx_data, 0);
        exp_q.delete();
        repeat (2) @(posedge clkin);
        #1;
        nrst = 1'b1;
        n0 = nbytes;
        push_frame(8'h01);
        send_cmd(8'h01, st);
        wait_idle(cyc);
        chk("r2_frame_len", nbytes - n0, 35);
        chk("r2_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
